// File: rtl/video_timing_gen_pkg.sv
// Shared types and constants for the PAL raster timing generator.
package video_timing_gen_pkg;

    typedef enum logic [1:0] {
        LINE_NORMAL = 2'd0,
        LINE_EQ     = 2'd1,
        LINE_BROAD  = 2'd2
    } line_type_t;

    localparam logic [8:0] FIELD_LEN_EVEN = 9'd312;
    localparam logic [8:0] FIELD_LEN_ODD  = 9'd313;

endpackage

// File: rtl/video_timing_gen_line_classifier.sv
// Combinational decode of a field line number into its sync line type and vertical blanking.
module video_line_classifier
    import video_timing_gen_pkg::*;
#(
    parameter int unsigned V_BLANK_END = 23
) (
    input  logic [8:0] y,
    input  logic [8:0] field_len,
    output line_type_t line_type,
    output logic       vblank
);

    logic tail_lines;

    // The last three lines of a field carry the post-field equalising pulses.
    assign tail_lines = (y >= (field_len - 9'd3));

    always_comb begin
        line_type = LINE_NORMAL;
        if (y <= 9'd2) begin
            line_type = LINE_BROAD;
        end else if ((y <= 9'd4) || tail_lines) begin
            line_type = LINE_EQ;
        end
    end

    assign vblank = (y < 9'(V_BLANK_END)) || tail_lines;

endmodule

// File: rtl/video_timing_gen.sv
// PAL raster timing generator: x/y counters, field parity, sync/blank/burst flags.
// Optional frame_count output is enabled by defining VIDEO_TIMING_FRAME_COUNTER_EN.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int unsigned H_TOTAL        = 3072,
    parameter int unsigned HSYNC_LEN      = 226,
    parameter int unsigned EQ_LEN         = 113,
    parameter int unsigned BURST_START    = 269,
    parameter int unsigned BURST_LEN      = 108,
    parameter int unsigned H_ACTIVE_START = 504,
    parameter int unsigned H_ACTIVE_END   = 3000,
    parameter int unsigned V_BLANK_END    = 23
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interlace,
    output logic        newframe,
    output logic        newline,
    output logic        even_field,
    output logic [8:0]  video_y,
    output logic [12:0] video_x,
    output logic        sync,
    output logic        blank,
    output logic        burst
`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
    ,
    output logic [15:0] frame_count
`endif
);

    localparam logic [12:0] X_LAST    = 13'(H_TOTAL - 1);
    localparam logic [13:0] C_HSYNC   = 14'(HSYNC_LEN);
    localparam logic [13:0] C_EQ      = 14'(EQ_LEN);
    localparam logic [13:0] C_HALF    = 14'(H_TOTAL / 2);
    localparam logic [13:0] C_HALF_EQ = 14'(H_TOTAL / 2 + EQ_LEN);
    localparam logic [13:0] C_BROAD_A = 14'(H_TOTAL / 2 - HSYNC_LEN);
    localparam logic [13:0] C_BROAD_B = 14'(H_TOTAL - HSYNC_LEN);
    localparam logic [13:0] C_BST     = 14'(BURST_START);
    localparam logic [13:0] C_BEND    = 14'(BURST_START + BURST_LEN);
    localparam logic [13:0] C_ACT_S   = 14'(H_ACTIVE_START);
    localparam logic [13:0] C_ACT_E   = 14'(H_ACTIVE_END);

    logic        lace_q;
    logic        line_end;
    logic        frame_end;
    logic [8:0]  field_len;
    logic [8:0]  len_nxt;
    logic [12:0] x_nxt;
    logic [13:0] xe_nxt;
    logic [8:0]  y_nxt;
    logic        lace_nxt;
    logic        ef_nxt;
    logic        sync_nxt;
    logic        blank_nxt;
    logic        burst_nxt;
    line_type_t  type_nxt;
    logic        vblank_nxt;

    // Odd (313-line) fields exist only while the latched mode is interlaced.
    assign field_len = (lace_q && !even_field) ? FIELD_LEN_ODD : FIELD_LEN_EVEN;
    assign line_end  = (video_x == X_LAST);
    assign frame_end = line_end && (video_y == (field_len - 9'd1));

    always_comb begin
        x_nxt    = line_end ? 13'd0 : (video_x + 13'd1);
        y_nxt    = video_y;
        lace_nxt = lace_q;
        ef_nxt   = even_field;
        if (line_end) begin
            y_nxt = frame_end ? 9'd0 : (video_y + 9'd1);
        end
        if (frame_end) begin
            lace_nxt = interlace;
            ef_nxt   = interlace ? ~even_field : 1'b1;
        end
    end

    assign len_nxt = (lace_nxt && !ef_nxt) ? FIELD_LEN_ODD : FIELD_LEN_EVEN;
    assign xe_nxt  = {1'b0, x_nxt};

    // Decode runs on the next position so the flags register alongside the counters.
    video_line_classifier #(
        .V_BLANK_END (V_BLANK_END)
    ) u_classifier (
        .y         (y_nxt),
        .field_len (len_nxt),
        .line_type (type_nxt),
        .vblank    (vblank_nxt)
    );

    always_comb begin
        sync_nxt = 1'b0;
        unique case (type_nxt)
            LINE_BROAD: sync_nxt = (xe_nxt < C_BROAD_A) ||
                                   ((xe_nxt >= C_HALF) && (xe_nxt < C_BROAD_B));
            LINE_EQ:    sync_nxt = (xe_nxt < C_EQ) ||
                                   ((xe_nxt >= C_HALF) && (xe_nxt < C_HALF_EQ));
            default:    sync_nxt = (xe_nxt < C_HSYNC);
        endcase
    end

    assign burst_nxt = (type_nxt == LINE_NORMAL) && (xe_nxt >= C_BST) && (xe_nxt < C_BEND);
    assign blank_nxt = vblank_nxt || (xe_nxt < C_ACT_S) || (xe_nxt >= C_ACT_E);

    // Reset parks the raster on the last clock of a field so release starts frame 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            video_x    <= X_LAST;
            video_y    <= FIELD_LEN_EVEN - 9'd1;
            even_field <= 1'b0;
            lace_q     <= 1'b0;
            newframe   <= 1'b0;
            newline    <= 1'b0;
            sync       <= 1'b0;
            blank      <= 1'b1;
            burst      <= 1'b0;
        end else begin
            video_x    <= x_nxt;
            video_y    <= y_nxt;
            even_field <= ef_nxt;
            lace_q     <= lace_nxt;
            newframe   <= frame_end;
            newline    <= line_end;
            sync       <= sync_nxt;
            blank      <= blank_nxt;
            burst      <= burst_nxt;
        end
    end

`ifdef VIDEO_TIMING_FRAME_COUNTER_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_count <= 16'd0;
        end else if (newframe) begin
            frame_count <= frame_count + 16'd1;
        end
    end
`endif

endmodule
